// File: rtl/div8_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div8_stream_ctrl
//  Purpose  : Streams operand pairs into an external 8-bit array divider,
//             waits for it to settle, and queues results in a 2-entry FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module div8_stream_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_dividend,
    input  logic [7:0]  in_divisor,
    output logic [7:0]  div_sbc,
    output logic [7:0]  div_sc,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_quot,
    output logic [7:0]  out_rem,
    output logic        out_dbz,
    output logic [15:0] op_count,
    output logic [7:0]  dbz_count
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_settle  = 2'd1;
    localparam logic [1:0] c_capture = 2'd2;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_dbz;
    logic [7:0]  r_sbc;
    logic [7:0]  r_sc;

    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [7:0]  r_mem_q [0:1];
    logic [7:0]  r_mem_r [0:1];
    logic        r_mem_z [0:1];

    logic [15:0] r_op_count;
    logic [7:0]  r_dbz_count;

    logic        w_accept;
    logic        w_full;
    logic        w_wr;
    logic        w_pop;

    assign in_ready  = rst_n && (r_state == c_idle);
    assign out_valid = rst_n && (r_count != 2'd0);

    assign w_accept = in_valid && in_ready;
    assign w_full   = (r_count == 2'd2);
    // A full FIFO blocks the write even when a pop happens on the same edge.
    assign w_wr     = (r_state == c_capture) && !w_full;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_state_nxt = (in_divisor == 8'd0) ? c_capture : c_settle;
                end
            end
            c_settle: begin
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = c_capture;
                end
            end
            c_capture: begin
                if (!w_full) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Operand registers stay frozen from acceptance until the return to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_dbz <= 1'b0;
            r_sbc <= 8'd0;
            r_sc  <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= 4'd0;
            r_dbz <= (in_divisor == 8'd0);
            r_sbc <= in_dividend;
            r_sc  <= in_divisor;
        end else if (r_state == c_settle) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_mem_q[0] <= 8'd0;
            r_mem_q[1] <= 8'd0;
            r_mem_r[0] <= 8'd0;
            r_mem_r[1] <= 8'd0;
            r_mem_z[0] <= 1'b0;
            r_mem_z[1] <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem_q[r_wptr] <= r_dbz ? 8'hFF : div_q;
                r_mem_r[r_wptr] <= r_dbz ? r_sbc : div_r;
                r_mem_z[r_wptr] <= r_dbz;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count  <= 16'd0;
            r_dbz_count <= 8'd0;
        end else if (w_wr) begin
            r_op_count <= r_op_count + 16'd1;
            if (r_dbz && (r_dbz_count != 8'hFF)) begin
                r_dbz_count <= r_dbz_count + 8'd1;
            end
        end
    end

    assign div_sbc   = r_sbc;
    assign div_sc    = r_sc;
    assign out_quot  = r_mem_q[r_rptr];
    assign out_rem   = r_mem_r[r_rptr];
    assign out_dbz   = r_mem_z[r_rptr];
    assign op_count  = r_op_count;
    assign dbz_count = r_dbz_count;

endmodule
`default_nettype wire

// File: tb/tb_div8_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div8_stream_ctrl
//  Purpose  : Scoreboard bench for div8_stream_ctrl with a behavioural divider.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div8_stream_ctrl;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_dividend;
    logic [7:0]  in_divisor;
    logic [7:0]  div_sbc;
    logic [7:0]  div_sc;
    logic [7:0]  div_q;
    logic [7:0]  div_r;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_quot;
    logic [7:0]  out_rem;
    logic        out_dbz;
    logic [15:0] op_count;
    logic [7:0]  dbz_count;

    int   tests_run    = 0;
    int   tests_failed = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the external combinational array divider.
    assign div_q = (div_sc == 8'd0) ? 8'hA5 : div_sbc / div_sc;
    assign div_r = (div_sc == 8'd0) ? 8'h5A : div_sbc % div_sc;

    div8_stream_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .div_sbc    (div_sbc),
        .div_sc     (div_sc),
        .div_q      (div_q),
        .div_r      (div_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quot   (out_quot),
        .out_rem    (out_rem),
        .out_dbz    (out_dbz),
        .op_count   (op_count),
        .dbz_count  (dbz_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Returns just after edge E0 with the expected result queued.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int   n = 0;
        res_t e;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_ready: in_ready=%b required 1 (op %0d/%0d)", in_ready, a, b);
        end
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        if (b == 8'd0) e = '{q: 8'hFF, r: a, z: 1'b1};
        else           e = '{q: a / b, r: a % b, z: 1'b0};
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_head(input string tag);
        res_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: head q=%0d r=%0d z=%b with no result expected", tag, out_quot, out_rem, out_dbz);
        end else begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || out_quot !== e.q || out_rem !== e.r || out_dbz !== e.z) begin
                tests_failed++;
                $display("FAIL %s: got v=%b q=%0d r=%0d z=%b required v=1 q=%0d r=%0d z=%b",
                         tag, out_valid, out_quot, out_rem, out_dbz, e.q, e.r, e.z);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_dividend = 8'd0; in_divisor = 8'd0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pre: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        repeat (3) tick();
        tests_run++;
        if (op_count !== 16'd0 || dbz_count !== 8'd0 || div_sbc !== 8'd0 || div_sc !== 8'd0
            || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ops=%0d dbz=%0d sbc=%0d sc=%0d rdy=%b v=%b required all 0",
                     op_count, dbz_count, div_sbc, div_sc, in_ready, out_valid);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_normal();
        logic [7:0] ta [5] = '{8'd0, 8'd255, 8'd17, 8'd100, 8'd129};
        logic [7:0] tb [5] = '{8'd5, 8'd1, 8'd255, 8'd10, 8'd16};
        int lat;
        out_ready = 1'b1;
        issue(8'd200, 8'd7);
        wait_valid(lat);
        tests_run++;
        if (lat != 3) begin
            tests_failed++;
            $display("FAIL lat_normal: latency %0d required 3", lat);
        end
        tests_run++;
        if (out_quot !== 8'd28 || out_rem !== 8'd4 || out_dbz !== 1'b0 || op_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL div_200_7: q=%0d r=%0d z=%b ops=%0d required 28 4 0 1",
                     out_quot, out_rem, out_dbz, op_count);
        end
        check_head("head_200_7");
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop_empty: out_valid=%b required 0", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i]);
            wait_valid(lat);
            tests_run++;
            if (lat != 3) begin
                tests_failed++;
                $display("FAIL lat_table%0d: latency %0d required 3", i, lat);
            end
            check_head($sformatf("head_table%0d", i));
            tick();
        end
        tests_run++;
        if (op_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL op_count_normal: got %0d required 6", op_count);
        end
    endtask

    task automatic test_dbz();
        int lat;
        logic [7:0] a;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = (i == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            issue(a, 8'd0);
            wait_valid(lat);
            tests_run++;
            if (lat != 1) begin
                tests_failed++;
                $display("FAIL lat_dbz%0d: latency %0d required 1", i, lat);
            end
            if (i == 0) begin
                tests_run++;
                if (dbz_count !== 8'd1 || out_quot !== 8'hFF || out_rem !== 8'hFF || out_dbz !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL dbz_first: cnt=%0d q=%0d r=%0d z=%b required 1 255 255 1",
                             dbz_count, out_quot, out_rem, out_dbz);
                end
            end
            check_head($sformatf("head_dbz%0d", i));
        end
        tick();
        tests_run++;
        if (dbz_count !== 8'd255 || op_count !== 16'd256 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL dbz_saturate: dbz=%0d ops=%0d v=%b required 255 256 0",
                     dbz_count, op_count, out_valid);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 1'b0;
        issue(8'd10, 8'd3);
        issue(8'd9, 8'd2);
        issue(8'd7, 8'd7);
        repeat (6) tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL stall_full: rdy=%b v=%b ops=%0d required 0 1 2", in_ready, out_valid, op_count);
        end
        out_ready = 1'b1;
        check_head("stall_head0");
        tick();
        check_head("stall_head1");
        tests_run++;
        if (op_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL stall_no_passthru: ops=%0d required 2", op_count);
        end
        tick();
        check_head("stall_head2");
        tests_run++;
        if (op_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL stall_retry: ops=%0d required 3", op_count);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_drain: v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        issue(8'd50, 8'd6);
        wait_valid(lat);
        issue(8'd81, 8'd9);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_settle_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || div_sbc !== 8'd81 || div_sc !== 8'd9) begin
            tests_failed++;
            $display("FAIL b2b_capture: rdy=%b sbc=%0d sc=%0d required 0 81 9", in_ready, div_sbc, div_sc);
        end
        out_ready = 1'b1;
        check_head("b2b_old_head");
        tick();
        check_head("b2b_new_head");
        tests_run++;
        if (op_count !== 16'd5 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_after_write: ops=%0d rdy=%b required 5 1", op_count, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_single_entry: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen = 1'b0;
        out_ready = 1'b0;
        issue(8'd20, 8'd3);
        wait_valid(lat);
        issue(8'd30, 8'd4);
        tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || op_count !== 16'd0 || dbz_count !== 8'd0
            || div_sbc !== 8'd0 || div_sc !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: v=%b rdy=%b ops=%0d dbz=%0d sbc=%0d sc=%0d required 0 0 0 0 0 0",
                     out_valid, in_ready, op_count, dbz_count, div_sbc, div_sc);
        end
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_release_ready: in_ready=%b required 1", in_ready);
        end
        out_ready = 1'b1;
        repeat (10) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || op_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_no_stale: seen=%b ops=%0d required 0 0", seen, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_dbz();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
